// File: rtl/rob_multiport.sv
// Reorder buffer: allocates an entry per dispatched instruction, collects results
// from NUM_WB writeback buses and retires up to RETIRE_W entries per cycle in program order.
module rob_multiport #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NUM_WB     = 3,
    parameter int unsigned RETIRE_W   = 2,
    parameter int unsigned PREG_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 12,
    localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [PREG_WIDTH-1:0]          disp_rd,
    input  logic [PREG_WIDTH-1:0]          disp_old_rd,
    input  logic [PC_WIDTH-1:0]            disp_pc,
    output logic [IDX_W-1:0]               disp_tag,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]        wb_tag,
    input  logic [NUM_WB*DATA_WIDTH-1:0]   wb_data,
    output logic [RETIRE_W-1:0]            ret_valid,
    output logic [RETIRE_W*PREG_WIDTH-1:0] ret_rd,
    output logic [RETIRE_W*PREG_WIDTH-1:0] ret_old_rd,
    output logic [RETIRE_W*DATA_WIDTH-1:0] ret_data,
    output logic [RETIRE_W*PC_WIDTH-1:0]   ret_pc,
    output logic [IDX_W:0]                 count,
    output logic                           empty,
    output logic                           full
);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned RN_W  = $clog2(RETIRE_W + 1);

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      done_q;
    logic [PREG_WIDTH-1:0] rd_q     [DEPTH];
    logic [PREG_WIDTH-1:0] old_rd_q [DEPTH];
    logic [PC_WIDTH-1:0]   pc_q     [DEPTH];
    logic [DATA_WIDTH-1:0] data_q   [DEPTH];
    logic [IDX_W-1:0]      head;
    logic [IDX_W-1:0]      tail;

    logic                  do_disp;
    logic [IDX_W-1:0]      wb_idx   [NUM_WB];
    logic [NUM_WB-1:0]     wb_hit;
    logic [IDX_W-1:0]      ret_idx  [RETIRE_W];
    logic [RETIRE_W-1:0]   ret_mask;
    logic [RN_W-1:0]       ret_n;
    logic                  blocked;

    // Status is derived from the registered occupancy only
    assign disp_ready = count < CNT_W'(DEPTH);
    assign full       = count == CNT_W'(DEPTH);
    assign empty      = count == '0;
    assign disp_tag   = tail;
    assign do_disp    = disp_valid && disp_ready;

    // Writebacks only land on entries that were already allocated before this edge
    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < int'(NUM_WB); i++) begin
            wb_idx[i] = wb_tag[i*IDX_W +: IDX_W];
            wb_hit[i] = wb_valid[i] && valid_q[wb_idx[i]];
        end
    end

    // Longest in-order prefix of completed entries starting at head
    always_comb begin
        ret_mask = '0;
        ret_n    = '0;
        blocked  = 1'b0;
        for (int k = 0; k < int'(RETIRE_W); k++) begin
            ret_idx[k] = head + IDX_W'(k);
            if (!blocked && valid_q[ret_idx[k]] && done_q[ret_idx[k]]) begin
                ret_mask[k] = 1'b1;
                ret_n       = ret_n + RN_W'(1);
            end else begin
                blocked = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            valid_q    <= '0;
            done_q     <= '0;
            ret_valid  <= '0;
            ret_rd     <= '0;
            ret_old_rd <= '0;
            ret_data   <= '0;
            ret_pc     <= '0;
        end else begin
            if (do_disp) begin
                valid_q[tail] <= 1'b1;
                done_q[tail]  <= 1'b0;
                tail          <= tail + IDX_W'(1);
            end
            for (int i = 0; i < int'(NUM_WB); i++) begin
                if (wb_hit[i]) begin
                    done_q[wb_idx[i]] <= 1'b1;
                end
            end
            for (int k = 0; k < int'(RETIRE_W); k++) begin
                if (ret_mask[k]) begin
                    valid_q[ret_idx[k]] <= 1'b0;
                end
                ret_valid[k]                             <= ret_mask[k];
                ret_rd[k*PREG_WIDTH +: PREG_WIDTH]       <= ret_mask[k] ? rd_q[ret_idx[k]] : '0;
                ret_old_rd[k*PREG_WIDTH +: PREG_WIDTH]   <= ret_mask[k] ? old_rd_q[ret_idx[k]] : '0;
                ret_data[k*DATA_WIDTH +: DATA_WIDTH]     <= ret_mask[k] ? data_q[ret_idx[k]] : '0;
                ret_pc[k*PC_WIDTH +: PC_WIDTH]           <= ret_mask[k] ? pc_q[ret_idx[k]] : '0;
            end
            head  <= head + IDX_W'(ret_n);
            count <= count + CNT_W'(do_disp) - CNT_W'(ret_n);
        end
    end

    // Payload storage; highest bus written first so the lowest-index bus wins a tag collision
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (do_disp) begin
                rd_q[tail]     <= disp_rd;
                old_rd_q[tail] <= disp_old_rd;
                pc_q[tail]     <= disp_pc;
            end
            for (int i = int'(NUM_WB) - 1; i >= 0; i--) begin
                if (wb_hit[i]) begin
                    data_q[wb_idx[i]] <= wb_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_multiport.sv
// Scoreboard bench for rob_multiport: a queue-based program-order model predicts
// retirements; a negedge monitor compares them against the retire ports.
module tb_rob_multiport;
    localparam int DEPTH = 16, NUM_WB = 3, RETIRE_W = 2;
    localparam int PW = 6, DW = 32, PCW = 12, IDX_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, flush, disp_valid, disp_ready, empty, full;
    logic [PW-1:0]          disp_rd, disp_old_rd;
    logic [PCW-1:0]         disp_pc;
    logic [IDX_W-1:0]       disp_tag;
    logic [NUM_WB-1:0]      wb_valid;
    logic [NUM_WB*IDX_W-1:0] wb_tag;
    logic [NUM_WB*DW-1:0]   wb_data;
    logic [RETIRE_W-1:0]    ret_valid;
    logic [RETIRE_W*PW-1:0] ret_rd, ret_old_rd;
    logic [RETIRE_W*DW-1:0] ret_data;
    logic [RETIRE_W*PCW-1:0] ret_pc;
    logic [IDX_W:0]         count;

    rob_multiport dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
        .disp_old_rd(disp_old_rd), .disp_pc(disp_pc), .disp_tag(disp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_old_rd(ret_old_rd),
        .ret_data(ret_data), .ret_pc(ret_pc),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        int             slot;
        logic [PW-1:0]  rd;
        logic [PW-1:0]  old_rd;
        logic [DW-1:0]  data;
        logic [PCW-1:0] pc;
        time            t;
    } ret_t;

    ret_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    // Reference model: in-flight tags in program order plus per-tag payload
    int             m_q[$];
    int             m_next = 0;
    bit             m_done [DEPTH];
    logic [PW-1:0]  m_rd   [DEPTH];
    logic [PW-1:0]  m_old  [DEPTH];
    logic [PCW-1:0] m_pc   [DEPTH];
    logic [DW-1:0]  m_data [DEPTH];

    logic           s_rst, s_fl, s_dv;
    logic [PW-1:0]  s_rd, s_old;
    logic [PCW-1:0] s_pc;
    logic [NUM_WB-1:0] s_wbv;
    int             s_wbt [NUM_WB];
    logic [DW-1:0]  s_wbd [NUM_WB];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_flight(input int t);
        foreach (m_q[j]) if (m_q[j] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        ret_t r;
        int   n, pre_cnt;
        bit   wrote [DEPTH];
        if (s_rst || s_fl) begin
            m_q.delete();
            m_next = 0;
            for (int j = 0; j < DEPTH; j++) m_done[j] = 1'b0;
            return;
        end
        pre_cnt = m_q.size();
        n = 0;
        while (n < RETIRE_W && n < m_q.size() && m_done[m_q[n]]) begin
            r.slot = n; r.rd = m_rd[m_q[n]]; r.old_rd = m_old[m_q[n]];
            r.data = m_data[m_q[n]]; r.pc = m_pc[m_q[n]]; r.t = $time;
            exp_q.push_back(r);
            n++;
        end
        for (int j = 0; j < DEPTH; j++) wrote[j] = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (s_wbv[i] && in_flight(s_wbt[i]) && !wrote[s_wbt[i]]) begin
                m_done[s_wbt[i]] = 1'b1;
                m_data[s_wbt[i]] = s_wbd[i];
                wrote[s_wbt[i]]  = 1'b1;
            end
        end
        repeat (n) void'(m_q.pop_front());
        if (s_dv && pre_cnt < DEPTH) begin
            m_rd[m_next] = s_rd; m_old[m_next] = s_old; m_pc[m_next] = s_pc;
            m_done[m_next] = 1'b0;
            m_q.push_back(m_next);
            m_next = (m_next + 1) % DEPTH;
        end
    endtask

    // Drive at negedge, advance model at posedge, check status at the next negedge
    task automatic step();
        rst = s_rst; flush = s_fl; disp_valid = s_dv;
        disp_rd = s_rd; disp_old_rd = s_old; disp_pc = s_pc;
        wb_valid = s_wbv;
        for (int i = 0; i < NUM_WB; i++) begin
            wb_tag[i*IDX_W +: IDX_W] = IDX_W'(s_wbt[i]);
            wb_data[i*DW +: DW]      = s_wbd[i];
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (mon_en) begin
            chk("count", 64'(count), 64'(m_q.size()));
            chk("empty", 64'(empty), 64'(m_q.size() == 0));
            chk("full", 64'(full), 64'(m_q.size() == DEPTH));
            chk("disp_ready", 64'(disp_ready), 64'(m_q.size() < DEPTH));
            chk("disp_tag", 64'(disp_tag), 64'(m_next));
        end
        s_rst = 0; s_fl = 0; s_dv = 0; s_wbv = '0;
    endtask

    task automatic disp(input int rd, input int old, input int pc);
        s_dv = 1; s_rd = PW'(rd); s_old = PW'(old); s_pc = PCW'(pc);
        step();
    endtask

    task automatic wb(input int bus, input int tag, input logic [DW-1:0] d);
        s_wbv[bus] = 1'b1; s_wbt[bus] = tag; s_wbd[bus] = d;
    endtask

    // Monitor: pops one expected record per presented retirement slot
    initial begin
        ret_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int k = 0; k < RETIRE_W; k++) begin
                    if (ret_valid[k] === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_ret slot=%0d pc=%0h at %0t", k, ret_pc[k*PCW +: PCW], $time);
                        end else begin
                            r = exp_q.pop_front();
                            chk("ret_slot", 64'(k), 64'(r.slot));
                            chk("ret_latency", 64'($time - r.t), 64'd5);
                            chk("ret_rd", 64'(ret_rd[k*PW +: PW]), 64'(r.rd));
                            chk("ret_old_rd", 64'(ret_old_rd[k*PW +: PW]), 64'(r.old_rd));
                            chk("ret_data", 64'(ret_data[k*DW +: DW]), 64'(r.data));
                            chk("ret_pc", 64'(ret_pc[k*PCW +: PCW]), 64'(r.pc));
                        end
                    end else begin
                        chk("ret_idle_zero", {8'h0, ret_rd[k*PW +: PW], ret_old_rd[k*PW +: PW],
                            ret_data[k*DW +: DW], ret_pc[k*PCW +: PCW]}, 64'd0);
                    end
                end
                while (exp_q.size() > 0 && exp_q[0].t + 5 <= $time) begin
                    checks++; errors++;
                    $display("FAIL missed_ret pc=%0h expected at %0t", exp_q[0].pc, exp_q[0].t + 5);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int cnt, ndisp;
        s_rst = 0; s_fl = 0; s_dv = 0; s_rd = '0; s_old = '0; s_pc = '0; s_wbv = '0;
        for (int i = 0; i < NUM_WB; i++) begin s_wbt[i] = 0; s_wbd[i] = '0; end

        // Reset then a single dispatch
        s_rst = 1; step();
        s_rst = 1; step();
        mon_en = 1;
        chk("reset_ret_valid", 64'(ret_valid), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_tag", 64'(disp_tag), 64'd0);
        disp(5, 1, 12'h004);
        chk("first_count", 64'(count), 64'd1);

        // Out-of-order completion
        disp(6, 2, 12'h008);
        disp(7, 3, 12'h00c);
        wb(0, 2, 32'h22); step();
        wb(1, 1, 32'h11); step();
        step(); step();
        wb(0, 0, 32'h100); step();
        chk("ooo_no_early_ret", 64'(ret_valid), 64'd0);
        step();
        chk("ooo_pair", 64'(ret_valid), 64'd3);
        step();
        chk("ooo_tail", 64'(ret_valid), 64'd1);
        chk("ooo_tail_data", 64'(ret_data[DW-1:0]), 64'h22);
        step();

        // Full and backpressure
        s_fl = 1; step();
        for (int i = 0; i < DEPTH; i++) disp(i, i + 1, 12'h100 + i * 4);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(disp_ready), 64'd0);
        disp(63, 63, 12'hfff);
        chk("full_hold", 64'(count), 64'd16);
        wb(0, 0, 32'h5); wb(1, 1, 32'h6); step();
        step();
        chk("after_ret_count", 64'(count), 64'd14);
        chk("after_ret_ready", 64'(disp_ready), 64'd1);

        // Flush mid-operation
        s_fl = 1; step();
        for (int i = 0; i < 6; i++) disp(i + 10, i, 12'h200 + i * 4);
        wb(0, 3, 32'h33); wb(1, 4, 32'h44); step();
        s_fl = 1; s_dv = 1; s_rd = 6'h3f; s_pc = 12'h777;
        wb(0, 0, 32'h1); wb(1, 1, 32'h2); wb(2, 2, 32'h3); step();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_ret", 64'(ret_valid), 64'd0);
        chk("flush_tag", 64'(disp_tag), 64'd0);

        // Simultaneous writebacks to one tag
        for (int i = 0; i < 4; i++) disp(i + 20, i + 30, 12'h300 + i * 4);
        wb(0, 3, 32'hA); wb(1, 3, 32'hB); wb(2, 3, 32'hC); step();
        wb(0, 0, 32'h0); wb(1, 1, 32'h1); wb(2, 2, 32'h2); step();
        step(); step();
        chk("multi_bus_valid", 64'(ret_valid), 64'd3);
        chk("multi_bus_data", 64'(ret_data[DW +: DW]), 64'hA);
        step();

        // Randomised traffic with 3..10 entries in flight, wrapping tags
        ndisp = 0;
        for (int c = 0; c < 400; c++) begin
            cnt = m_q.size();
            s_dv = (cnt < 3) ? 1'b1 : (cnt >= 10) ? 1'b0 : 1'($urandom_range(0, 1));
            s_rd = PW'($urandom); s_old = PW'($urandom); s_pc = PCW'($urandom);
            if (s_dv && cnt < DEPTH) ndisp++;
            for (int i = 0; i < NUM_WB; i++) begin
                if ($urandom_range(0, 99) < 40) begin
                    if (m_q.size() > 0 && $urandom_range(0, 99) < 85)
                        wb(i, m_q[$urandom_range(0, m_q.size() - 1)], $urandom);
                    else
                        wb(i, $urandom_range(0, DEPTH - 1), $urandom);
                end
            end
            step();
        end
        chk("random_volume", 64'(ndisp >= 40), 64'd1);

        // Drain remaining entries
        for (int c = 0; c < 200 && m_q.size() > 0; c++) begin
            wb(0, m_q[0], $urandom);
            wb(1, m_q[m_q.size() - 1], $urandom);
            step();
        end
        step(); step(); step();
        chk("drain_empty", 64'(empty), 64'd1);
        chk("pending_retires", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
